// File: rtl/urv_pipe_ctrl_if.sv
// Stall/kill/redirect/divide/debug signal bundle between urv_pipe_ctrl and the
// uRV stage modules.
//   master : the pipeline controller. It takes the per-stage requests and
//            drives the per-stage stall/kill and status outputs.
//   slave  : the stage side. It drives the requests and receives stall/kill.
interface urv_pipe_ctrl_if;
  logic f_stall_req_i;
  logic d_stall_req_i;
  logic x_stall_req_i;
  logic w_stall_req_i;
  logic x_redirect_i;
  logic x_div_start_i;
  logic dbg_halt_req_i;
  logic dbg_resume_i;

  logic f_stall_o;
  logic d_stall_o;
  logic x_stall_o;
  logic w_stall_o;
  logic f_kill_o;
  logic d_kill_o;
  logic x_kill_o;
  logic x_div_done_o;
  logic div_busy_o;
  logic dbg_halted_o;

  modport master (
    input  f_stall_req_i, d_stall_req_i, x_stall_req_i, w_stall_req_i,
    input  x_redirect_i, x_div_start_i, dbg_halt_req_i, dbg_resume_i,
    output f_stall_o, d_stall_o, x_stall_o, w_stall_o,
    output f_kill_o, d_kill_o, x_kill_o,
    output x_div_done_o, div_busy_o, dbg_halted_o
  );

  modport slave (
    output f_stall_req_i, d_stall_req_i, x_stall_req_i, w_stall_req_i,
    output x_redirect_i, x_div_start_i, dbg_halt_req_i, dbg_resume_i,
    input  f_stall_o, d_stall_o, x_stall_o, w_stall_o,
    input  f_kill_o, d_kill_o, x_kill_o,
    input  x_div_done_o, div_busy_o, dbg_halted_o
  );
endinterface

// File: rtl/urv_pipe_ctrl.sv
// Central uRV pipeline sequencer.
//
// It combines the per-stage stall requests, X-stage redirects and multi-cycle
// divide issue into the stall and kill controls for the F/D/X/W stages. It
// also owns the divide busy counter. It owns the debug halt sequence only when
// the debug halt macro described below is defined.
//
// Ports:
//   clk_i : core clock
//   rst_i : synchronous active-high reset
//   bus   : urv_pipe_ctrl_if.master. Inputs are the stall requests, redirect,
//           divide start and debug halt/resume. Outputs are the per-stage
//           stall/kill, x_div_done_o, div_busy_o and dbg_halted_o.
//
// Parameters:
//   g_div_cycles  : X-stage cycles a divide occupies (2..63)
//   g_kill_cycles : cycles F/D kill stays high after a redirect (1..7)
//
// Build option:
//   URV_PIPE_CTRL_DEBUG_EN : enables the debug halt/resume sequence. When it
//   is not defined, the debug inputs are ignored and dbg_halted_o is 0.
module urv_pipe_ctrl #(
  parameter int unsigned g_div_cycles  = 32,
  parameter int unsigned g_kill_cycles = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  urv_pipe_ctrl_if.master  bus
);

  localparam int unsigned DIV_CNT_W  = 6;
  localparam int unsigned KILL_CNT_W = 3;

  typedef enum logic [1:0] {RUN, DIV, HALT_WAIT, HALTED} state_t;

  state_t                  state, state_nxt;
  logic [DIV_CNT_W-1:0]    div_cnt, div_cnt_nxt;
  logic [KILL_CNT_W-1:0]   kill_cnt, kill_cnt_nxt;
  logic                    halt_first, halt_first_nxt;

  logic run;
  logic div_start, div_done, div_hold;
  logic halt_stall;
  logic w_stall, x_hold, x_stall, f_stall;
  logic redirect_acc, kill_active, kill_free;

`ifdef URV_PIPE_CTRL_DEBUG_EN
  assign halt_stall = (state == HALTED);
`else
  assign halt_stall = 1'b0;
  logic unused_dbg;
  assign unused_dbg = bus.dbg_halt_req_i ^ bus.dbg_resume_i;
`endif

  // Everything except the kills is forced low while reset is asserted.
  assign run       = ~rst_i;
  assign div_start = run & (state == RUN) & bus.x_div_start_i;
  assign div_done  = (state == DIV) & (div_cnt == DIV_CNT_W'(1));
  assign div_hold  = (state == DIV) & ~div_done;

  // Back-propagating stall chain.
  // x_hold leaves out the divide start cycle so that a redirect retiring
  // alongside a new divide is still accepted.
  assign w_stall = run & (bus.w_stall_req_i | halt_stall);
  assign x_hold  = run & (w_stall | bus.x_stall_req_i | div_hold | halt_stall);
  assign x_stall = x_hold | div_start;
  assign f_stall = run & (x_stall | bus.d_stall_req_i | bus.f_stall_req_i | halt_stall);

  assign redirect_acc = run & bus.x_redirect_i & ~x_hold;
  assign kill_active  = (kill_cnt != '0);
  assign kill_free    = ~redirect_acc & ~kill_active;

  assign bus.w_stall_o    = w_stall;
  assign bus.x_stall_o    = x_stall;
  assign bus.d_stall_o    = x_stall;
  assign bus.f_stall_o    = f_stall;
  assign bus.f_kill_o     = rst_i | redirect_acc | kill_active;
  assign bus.d_kill_o     = rst_i | redirect_acc | kill_active;
  assign bus.x_kill_o     = rst_i | halt_first;
  assign bus.x_div_done_o = run & div_done;
  assign bus.div_busy_o   = run & (state == DIV);
  assign bus.dbg_halted_o = run & (state == HALTED);

  // Next-state and counter logic.
  always_comb begin
    state_nxt      = state;
    div_cnt_nxt    = div_cnt;
    kill_cnt_nxt   = kill_cnt;
    halt_first_nxt = 1'b0;

    // A redirect inside the kill window restarts the window.
    if (redirect_acc) begin
      kill_cnt_nxt = KILL_CNT_W'(g_kill_cycles - 1);
    end else if (kill_active) begin
      kill_cnt_nxt = kill_cnt - KILL_CNT_W'(1);
    end

    unique case (state)
      RUN: begin
        if (div_start) begin
          state_nxt   = DIV;
          div_cnt_nxt = DIV_CNT_W'(g_div_cycles - 1);
        end
`ifdef URV_PIPE_CTRL_DEBUG_EN
        else if (bus.dbg_halt_req_i && kill_free) begin
          state_nxt = HALT_WAIT;
        end
`endif
      end
      DIV: begin
        div_cnt_nxt = div_cnt - DIV_CNT_W'(1);
        if (div_done) begin
          state_nxt = RUN;
`ifdef URV_PIPE_CTRL_DEBUG_EN
          // A halt request deferred during the divide is taken right away.
          if (bus.dbg_halt_req_i && kill_free) state_nxt = HALT_WAIT;
`endif
        end
      end
`ifdef URV_PIPE_CTRL_DEBUG_EN
      HALT_WAIT: begin
        if (!bus.x_stall_req_i && !bus.w_stall_req_i) begin
          state_nxt      = HALTED;
          halt_first_nxt = 1'b1;
        end
      end
      HALTED: begin
        if (bus.dbg_resume_i) state_nxt = RUN;
      end
`endif
      default: state_nxt = RUN;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      div_cnt    <= '0;
      kill_cnt   <= '0;
      halt_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      kill_cnt   <= kill_cnt_nxt;
      halt_first <= halt_first_nxt;
    end
  end

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Self-checking bench for urv_pipe_ctrl with the default parameters
// (g_div_cycles = 32, g_kill_cycles = 2).
// Single-cycle stall and redirect patterns come from a vector table. The
// divide, redirect-window, reset and debug cases are driven as sequences.
module tb_urv_pipe_ctrl;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  urv_pipe_ctrl_if bus ();

  urv_pipe_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic f_req, d_req, x_req, w_req, redir, div_start, halt_req, resume;
  } in_t;

  typedef struct packed {
    logic fs, ds, xs, ws, fk, dk, xk, done, busy, halted;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  out_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  function automatic in_t mk_in(bit f, bit d, bit x, bit w, bit r, bit ds, bit h, bit rs);
    mk_in = {f, d, x, w, r, ds, h, rs};
  endfunction

  function automatic out_t mk_out(bit fs, bit ds, bit xs, bit ws, bit fk, bit dk,
                                  bit xk, bit dn, bit bz, bit hl);
    mk_out = {fs, ds, xs, ws, fk, dk, xk, dn, bz, hl};
  endfunction

  task automatic drive(input logic r, input in_t in);
    rst                = r;
    bus.f_stall_req_i  = in.f_req;
    bus.d_stall_req_i  = in.d_req;
    bus.x_stall_req_i  = in.x_req;
    bus.w_stall_req_i  = in.w_req;
    bus.x_redirect_i   = in.redir;
    bus.x_div_start_i  = in.div_start;
    bus.dbg_halt_req_i = in.halt_req;
    bus.dbg_resume_i   = in.resume;
  endtask

  task automatic check(input string nm);
    out_t got, e;
    got = {bus.f_stall_o, bus.d_stall_o, bus.x_stall_o, bus.w_stall_o,
           bus.f_kill_o, bus.d_kill_o, bus.x_kill_o,
           bus.x_div_done_o, bus.div_busy_o, bus.dbg_halted_o};
    e = exp_q.pop_front();
    vec_cnt++;
    if (got !== e) begin
      err_cnt++;
      $display("FAIL %s: fs/ds/xs/ws/fk/dk/xk/done/busy/halted got %b required %b",
               nm, got, e);
    end
  endtask

  // Drive one cycle, queue its expectation, and compare at the falling edge.
  task automatic cycle(input string nm, input logic r, input in_t in, input out_t exp);
    drive(r, in);
    exp_q.push_back(exp);
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    in_t  in;
    out_t o_idle, o_rst, o_kill, o_s3;
    logic s;

    o_idle = '0;
    o_rst  = mk_out(0,0,0,0, 1,1,1, 0,0,0);
    o_kill = mk_out(0,0,0,0, 1,1,0, 0,0,0);
    o_s3   = mk_out(1,1,1,0, 0,0,0, 0,0,0);

    //                     f d x w r ds h rs        fs ds xs ws fk dk xk dn bz hl
    tbl[0]  = '{mk_in(0,1,0,0,0,0,0,0), mk_out(1,0,0,0, 0,0,0, 0,0,0)};
    tbl[1]  = '{mk_in(1,0,0,0,0,0,0,0), mk_out(1,0,0,0, 0,0,0, 0,0,0)};
    tbl[2]  = '{mk_in(0,0,1,0,0,0,0,0), mk_out(1,1,1,0, 0,0,0, 0,0,0)};
    tbl[3]  = '{mk_in(0,0,0,1,0,0,0,0), mk_out(1,1,1,1, 0,0,0, 0,0,0)};
    tbl[4]  = '{mk_in(0,0,0,1,1,0,0,0), mk_out(1,1,1,1, 0,0,0, 0,0,0)};
    tbl[5]  = '{mk_in(0,0,0,0,1,0,0,0), mk_out(0,0,0,0, 1,1,0, 0,0,0)};
    tbl[6]  = '{mk_in(0,0,0,0,0,0,0,0), mk_out(0,0,0,0, 1,1,0, 0,0,0)};
    tbl[7]  = '{mk_in(0,0,1,0,1,0,0,0), mk_out(1,1,1,0, 0,0,0, 0,0,0)};
    tbl[8]  = '{mk_in(0,0,0,0,0,0,0,0), mk_out(0,0,0,0, 0,0,0, 0,0,0)};
    tbl[9]  = '{mk_in(0,1,0,0,1,0,0,0), mk_out(1,0,0,0, 1,1,0, 0,0,0)};
    tbl[10] = '{mk_in(0,0,0,0,0,0,0,0), mk_out(0,0,0,0, 1,1,0, 0,0,0)};

    // Reset held for three cycles, then the first free-running cycle.
    for (int i = 0; i < 3; i++) cycle("reset", 1'b1, '0, o_rst);
    cycle("reset_release", 1'b0, '0, o_idle);
    cycle("idle", 1'b0, '0, o_idle);

    // Single-cycle stall/redirect patterns from the table.
    for (int i = 0; i < 11; i++) cycle($sformatf("vec%0d", i), 1'b0, tbl[i].in, tbl[i].exp);
    cycle("vec_tail", 1'b0, '0, o_idle);

    // A back-to-back redirect extends the kill window by one cycle.
    cycle("redir_a", 1'b0, mk_in(0,0,0,0,1,0,0,0), o_kill);
    cycle("redir_b", 1'b0, mk_in(0,0,0,0,1,0,0,0), o_kill);
    cycle("redir_ext", 1'b0, '0, o_kill);
    cycle("redir_end", 1'b0, '0, o_idle);

    // Divide with a redirect in the start cycle. A second start at k=5 and a
    // redirect at k=10 land while X is held, so both must be ignored.
    for (int k = 0; k <= 32; k++) begin
      in = '0;
      if (k == 0)  begin in.div_start = 1'b1; in.redir = 1'b1; end
      if (k == 5)  in.div_start = 1'b1;
      if (k == 10) in.redir = 1'b1;
      s = (k <= 30);
      cycle($sformatf("div_k%0d", k), 1'b0, in,
            mk_out(s, s, s, 1'b0, k <= 1, k <= 1, 1'b0,
                   k == 31, (k >= 1) && (k <= 31), 1'b0));
    end

    // Reset during a divide: no done pulse afterwards, back in RUN.
    cycle("divrst_start", 1'b0, mk_in(0,0,0,0,0,1,0,0), o_s3);
    for (int k = 1; k <= 3; k++)
      cycle("divrst_busy", 1'b0, '0, mk_out(1,1,1,0, 0,0,0, 0,1,0));
    cycle("divrst_rst0", 1'b1, '0, o_rst);
    cycle("divrst_rst1", 1'b1, '0, o_rst);
    for (int k = 0; k < 30; k++) cycle("divrst_after", 1'b0, '0, o_idle);
    cycle("divrst_redir", 1'b0, mk_in(0,0,0,0,1,0,0,0), o_kill);
    cycle("divrst_redir1", 1'b0, '0, o_kill);
    cycle("divrst_idle", 1'b0, '0, o_idle);

`ifdef URV_PIPE_CTRL_DEBUG_EN
    // A halt requested during a divide is taken two cycles after the done pulse.
    for (int k = 0; k <= 31; k++) begin
      in = mk_in(0,0,0,0,0, k == 0, 1, 0);
      s = (k <= 30);
      cycle($sformatf("halt_div_k%0d", k), 1'b0, in,
            mk_out(s, s, s, 1'b0, 1'b0, 1'b0, 1'b0, k == 31, k >= 1, 1'b0));
    end
    cycle("halt_wait", 1'b0, mk_in(0,0,0,0,0,0,1,0), o_idle);
    cycle("halted_first", 1'b0, mk_in(0,0,0,0,0,0,1,0), mk_out(1,1,1,1, 0,0,1, 0,0,1));
    cycle("halted", 1'b0, mk_in(0,0,0,0,0,0,1,0), mk_out(1,1,1,1, 0,0,0, 0,0,1));
    cycle("resume", 1'b0, mk_in(0,0,0,0,0,0,0,1), mk_out(1,1,1,1, 0,0,0, 0,0,1));
    cycle("resumed", 1'b0, '0, o_idle);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
